// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// instruction_loader_pkg : shared state encoding and word constants
// Revision 1.0
// ------------------------------------------------------------------
package instruction_loader_pkg;

  localparam int c_INSTR_WIDTH = 32;
  localparam logic [c_INSTR_WIDTH-1:0] c_HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_loader_if.sv
`default_nettype none
// ------------------------------------------------------------------
// instruction_loader_if : byte stream in, instruction-memory write out
// Revision 1.0
// ------------------------------------------------------------------
interface instruction_loader_if;

  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_write_instruction_flag;
  logic [31:0] o_instruction_to_write;
  logic [31:0] o_address_to_write_inst;

  modport master (
    input  i_rx_data,
    input  i_rx_valid,
    output o_write_instruction_flag,
    output o_instruction_to_write,
    output o_address_to_write_inst
  );

  modport slave (
    output i_rx_data,
    output i_rx_valid,
    input  o_write_instruction_flag,
    input  o_instruction_to_write,
    input  o_address_to_write_inst
  );

endinterface
`default_nettype wire

// File: rtl/instruction_loader_byte_word_assembler.sv
`default_nettype none
// ------------------------------------------------------------------
// byte_word_assembler : packs bytes little-endian into 32-bit words
// Revision 1.0
// ------------------------------------------------------------------
module byte_word_assembler
  import instruction_loader_pkg::*;
(
  input  wire logic                     i_clk,
  input  wire logic                     i_reset_n,
  input  wire logic                     i_clear,
  input  wire logic [7:0]               i_byte,
  input  wire logic                     i_valid,
  output logic      [c_INSTR_WIDTH-1:0] o_word,
  output logic                          o_word_valid
);

  logic [1:0]  r_count;
  logic [23:0] r_lanes;

  // Lane 3 is taken straight from the fourth byte so the word is ready on that cycle.
  assign o_word       = {i_byte, r_lanes};
  assign o_word_valid = i_valid && !i_clear && (r_count == 2'd3);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= 2'd0;
      r_lanes <= 24'd0;
    end else if (i_clear) begin
      r_count <= 2'd0;
    end else if (i_valid) begin
      r_count <= r_count + 2'd1;
      case (r_count)
        2'd0:    r_lanes[7:0]   <= i_byte;
        2'd1:    r_lanes[15:8]  <= i_byte;
        2'd2:    r_lanes[23:16] <= i_byte;
        default: r_lanes        <= r_lanes;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ------------------------------------------------------------------
// instruction_loader : loads instruction memory from a byte stream
// Revision 1.0
// ------------------------------------------------------------------
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int                         ADDR_WIDTH = 8,
  parameter logic [c_INSTR_WIDTH-1:0]   HALT_WORD  = c_HALT_WORD_DEFAULT
) (
  input  wire logic             i_clk,
  input  wire logic             i_reset_n,
  input  wire logic             i_start,
  instruction_loader_if.master  bus,
  output logic                  o_cpu_halt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_full
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_STEP = ADDR_WIDTH'(4);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic                     r_wr_flag;
  logic [c_INSTR_WIDTH-1:0] r_wr_data;
  logic [31:0]              r_wr_addr;
  logic                     r_full;

  logic                     w_start_ok;
  logic                     w_rx_valid;
  logic [c_INSTR_WIDTH-1:0] w_word;
  logic                     w_word_valid;
  logic                     w_halt_hit;
  logic                     w_mem_end;

  assign w_start_ok = i_start && (r_state != ST_LOAD);
  assign w_rx_valid = bus.i_rx_valid && (r_state == ST_LOAD);
  assign w_halt_hit = r_wr_flag && (r_wr_data == HALT_WORD);
  assign w_mem_end  = r_wr_flag && (r_addr == c_LAST_ADDR);

  byte_word_assembler u_assembler (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (w_start_ok),
    .i_byte       (bus.i_rx_data),
    .i_valid      (w_rx_valid),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_cpu_halt   = 1'b1;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        o_busy = 1'b1;
        if (w_halt_hit || w_mem_end) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        o_cpu_halt = 1'b0;
        o_done     = 1'b1;
        if (i_start) w_next_state = ST_LOAD;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The strobe cycle is always spent in LOAD, so the address step and exit checks key off r_wr_flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr    <= '0;
      r_wr_flag <= 1'b0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
      r_full    <= 1'b0;
    end else begin
      r_wr_flag <= w_word_valid;
      if (w_word_valid) begin
        r_wr_data <= w_word;
        r_wr_addr <= 32'(r_addr);
      end
      if (w_start_ok) begin
        r_addr <= '0;
        r_full <= 1'b0;
      end else if (r_wr_flag && !w_halt_hit) begin
        if (w_mem_end) r_full <= 1'b1;
        else           r_addr <= r_addr + c_ADDR_STEP;
      end
    end
  end

  assign bus.o_write_instruction_flag = r_wr_flag;
  assign bus.o_instruction_to_write   = r_wr_data;
  assign bus.o_address_to_write_inst  = r_wr_addr;
  assign o_full                       = r_full;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_instruction_loader : directed stimulus with a write-strobe scoreboard
// Revision 1.0
// ------------------------------------------------------------------
module tb_instruction_loader;

  localparam int          ADDR_WIDTH = 8;
  localparam logic [31:0] HALT       = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic r_clk   = 1'b0;
  logic r_rst_n = 1'b0;
  logic r_start = 1'b0;
  logic w_halt, w_busy, w_done, w_full;

  exp_t q_exp[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_strobes = 0;

  instruction_loader_if u_bus ();

  instruction_loader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .HALT_WORD  (HALT)
  ) dut (
    .i_clk      (r_clk),
    .i_reset_n  (r_rst_n),
    .i_start    (r_start),
    .bus        (u_bus),
    .o_cpu_halt (w_halt),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_full     (w_full)
  );

  always #5 r_clk = ~r_clk;

  // Monitor: every write strobe must match the oldest expected word.
  always @(negedge r_clk) begin : monitor
    exp_t e;
    if (u_bus.o_write_instruction_flag === 1'b1) begin
      n_strobes++;
      n_checks++;
      if (q_exp.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got addr=%h data=%h, required no strobe",
                 u_bus.o_address_to_write_inst, u_bus.o_instruction_to_write);
      end else begin
        e = q_exp.pop_front();
        if (u_bus.o_address_to_write_inst !== e.addr || u_bus.o_instruction_to_write !== e.data) begin
          n_fail++;
          $display("FAIL strobe_word: got addr=%h data=%h, required addr=%h data=%h",
                   u_bus.o_address_to_write_inst, u_bus.o_instruction_to_write, e.addr, e.data);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [31:0] a, input logic [31:0] d);
    q_exp.push_back('{addr: a, data: d});
  endtask

  task automatic send_byte(input logic [7:0] b);
    u_bus.i_rx_data  = b;
    u_bus.i_rx_valid = 1'b1;
    cyc();
    u_bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    r_start = 1'b1;
    cyc();
    r_start = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (q_exp.size() != 0 && t < 40) begin
      cyc();
      t++;
    end
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d strobes still pending after timeout, required 0", name, q_exp.size());
      q_exp.delete();
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_halt"}, 32'(w_halt), 32'd1);
    chk({tag, "_busy"}, 32'(w_busy), 32'd0);
    chk({tag, "_done"}, 32'(w_done), 32'd0);
    chk({tag, "_full"}, 32'(w_full), 32'd0);
    chk({tag, "_flag"}, 32'(u_bus.o_write_instruction_flag), 32'd0);
    chk({tag, "_data"}, u_bus.o_instruction_to_write, 32'd0);
    chk({tag, "_addr"}, u_bus.o_address_to_write_inst, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] w;
    u_bus.i_rx_data  = 8'h00;
    u_bus.i_rx_valid = 1'b0;

    // Test 1: reset state, basic word then halt marker
    cyc(3);
    chk_reset_state("reset");
    r_rst_n = 1'b1;
    cyc();
    chk("idle_halt", 32'(w_halt), 32'd1);
    pulse_start();
    chk("t1_busy", 32'(w_busy), 32'd1);
    expect_word(32'd0, 32'h2000_0013);
    expect_word(32'd4, HALT);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    chk("t1_latency_strobe", 32'(u_bus.o_write_instruction_flag), 32'd1);
    send_word(HALT);
    drain("t1_drain");
    cyc();
    chk("t1_done", 32'(w_done), 32'd1);
    chk("t1_full", 32'(w_full), 32'd0);
    chk("t1_halt", 32'(w_halt), 32'd0);
    chk("t1_busy_end", 32'(w_busy), 32'd0);
    chk("t1_hold_data", u_bus.o_instruction_to_write, HALT);
    chk("t1_hold_addr", u_bus.o_address_to_write_inst, 32'd4);

    // Test 2: back-to-back bytes, one coincident with each strobe
    pulse_start();
    chk("t2_done_cleared", 32'(w_done), 32'd0);
    n_strobes = 0;
    expect_word(32'd0,  32'h4433_2211);
    expect_word(32'd4,  32'h8877_6655);
    expect_word(32'd8,  32'hCCBB_AA99);
    expect_word(32'd12, HALT);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    send_word(32'hCCBB_AA99);
    send_word(HALT);
    drain("t2_drain");
    cyc();
    chk("t2_strobe_count", 32'(n_strobes), 32'd4);
    chk("t2_done", 32'(w_done), 32'd1);

    // Test 3: fill memory without a halt marker
    pulse_start();
    n_strobes = 0;
    for (int i = 0; i < 64; i++) begin
      w = {8'h01, 8'hA5, 8'h5A, 8'(i)};
      expect_word(32'(i * 4), w);
      send_word(w);
    end
    drain("t3_drain");
    cyc();
    chk("t3_done", 32'(w_done), 32'd1);
    chk("t3_full", 32'(w_full), 32'd1);
    chk("t3_strobe_count", 32'(n_strobes), 32'd64);
    chk("t3_last_addr", u_bus.o_address_to_write_inst, 32'd252);
    send_word(32'h0000_0001);
    cyc(5);
    chk("t3_no_65th_strobe", 32'(n_strobes), 32'd64);
    chk("t3_full_held", 32'(w_full), 32'd1);

    // Test 4: start during LOAD is ignored
    pulse_start();
    chk("t4_full_cleared", 32'(w_full), 32'd0);
    send_byte(8'h01); send_byte(8'h02);
    pulse_start();
    chk("t4_still_busy", 32'(w_busy), 32'd1);
    expect_word(32'd0, 32'h0403_0201);
    expect_word(32'd4, HALT);
    send_byte(8'h03); send_byte(8'h04);
    send_word(HALT);
    drain("t4_drain");
    cyc();
    chk("t4_done", 32'(w_done), 32'd1);

    // Test 5: reset in the middle of a word
    pulse_start();
    send_byte(8'hAA); send_byte(8'hBB);
    r_rst_n = 1'b0;
    cyc(2);
    chk_reset_state("t5_in_reset");
    r_rst_n = 1'b1;
    cyc(2);
    chk("t5_flag_after_reset", 32'(u_bus.o_write_instruction_flag), 32'd0);
    pulse_start();
    expect_word(32'd0, 32'h4030_2010);
    expect_word(32'd4, HALT);
    send_word(32'h4030_2010);
    send_word(HALT);
    drain("t5_drain");
    cyc();
    chk("t5_done", 32'(w_done), 32'd1);

    // Test 6: restart from DONE with a coincident byte that must be ignored
    u_bus.i_rx_data  = 8'hEE;
    u_bus.i_rx_valid = 1'b1;
    r_start          = 1'b1;
    cyc();
    r_start          = 1'b0;
    u_bus.i_rx_valid = 1'b0;
    chk("t6_done_cleared", 32'(w_done), 32'd0);
    chk("t6_busy", 32'(w_busy), 32'd1);
    expect_word(32'd0, 32'hDEAD_BEEF);
    expect_word(32'd4, HALT);
    send_word(32'hDEAD_BEEF);
    send_word(HALT);
    drain("t6_drain");
    cyc();
    chk("t6_done", 32'(w_done), 32'd1);
    chk("t6_full", 32'(w_full), 32'd0);
    chk("t6_final_addr", u_bus.o_address_to_write_inst, 32'd4);

    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Sequences programming of the instruction memory in the fetch stage from a byte stream (UART receiver or debug unit).
- Packs bytes into 32-bit words and drives the fetch stage's write-flag, write-data and write-address inputs.
- Holds the pipeline halted while loading and reports completion.
- Sits between the debug/UART front end and the instruction-fetch stage.

Parameters:
- ADDR_WIDTH, 8, byte-address width of instruction memory (2^ADDR_WIDTH bytes, word-aligned writes).
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; written to memory, then loading ends.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle pulse; begins a load at address 0 (accepted in IDLE or DONE only).
- i_rx_data  input  8  received byte.
- i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid. No backpressure exists.
- o_write_instruction_flag  output  1  one-cycle write strobe to instruction memory.
- o_instruction_to_write  output  32  assembled word.
- o_address_to_write_inst  output  32  byte address of the word; upper bits zero above ADDR_WIDTH.
- o_cpu_halt  output  1  high while loading; drives the fetch/pipeline halt.
- o_busy  output  1  high in LOAD.
- o_done  output  1  high in DONE until the next i_start.
- o_full  output  1  high in DONE when loading ended by memory exhaustion rather than HALT_WORD.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; byte counter=0; word address=0.
  - All outputs 0 except o_cpu_halt=1.
  - A partial word is discarded; no write strobe is issued after reset.
- States:
  - IDLE: o_cpu_halt=1. i_start -> LOAD, address=0, byte counter=0, o_full cleared.
  - LOAD: o_busy=1, o_cpu_halt=1.
    - Each i_rx_valid stores i_rx_data into byte lane [counter], little-endian (first byte -> bits [7:0], fourth -> [31:24]). Counter increments mod 4.
    - On the 4th byte, the word is registered. On the next cycle o_write_instruction_flag=1 for exactly 1 cycle, with o_instruction_to_write=word and o_address_to_write_inst=current address.
    - After the strobe, address += 4.
  - DONE: o_done=1, o_cpu_halt=0, o_write_instruction_flag=0. i_rx_valid is ignored. i_start -> LOAD (restart at address 0; o_done, o_full cleared).
- Leaving LOAD:
  - Written word == HALT_WORD: the strobe cycle still writes it, then -> DONE with o_full=0.
  - Strobe at address 2^ADDR_WIDTH-4 (last word): -> DONE with o_full=1. The address never wraps.
  - HALT_WORD at the last address: o_full=0 (the marker takes priority).
- Byte intake runs in parallel with the write strobe. An i_rx_valid in the strobe cycle is captured as byte 0 of the next word; no byte is lost.
- Latency: 4th byte strobe at cycle N -> write strobe at cycle N+1 -> address updated at N+2.
- i_start while in LOAD is ignored.
- Simultaneous i_start and i_rx_valid in IDLE/DONE: start takes effect; the byte is ignored.
- o_instruction_to_write and o_address_to_write_inst are registered and hold their last values between strobes. Their reset value is 0.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2); default HALT_WORD; instruction width 32.
- One natural sub-module: byte_word_assembler.
  - Inputs: byte, valid, clear.
  - Outputs: 32-bit word, word_valid pulse.
  - Contains the mod-4 counter and lane registers.
- The FSM, address counter and strobe generation stay in instruction_loader.

Test Plan:
1. Reset; i_start; bytes 13,00,00,20 then FF,FF,FF,FF -> strobe addr 0 data 32'h2000_0013; strobe addr 4 data 32'hFFFF_FFFF; o_done=1, o_full=0, o_cpu_halt=0.
2. Bytes issued back-to-back every cycle, including one coincident with a write strobe -> every word assembled correctly; strobe count = bytes/4.
3. ADDR_WIDTH=8; stream 64 non-halt words -> last strobe at addr 252; o_done=1, o_full=1; a 65th word produces no strobe.
4. i_start pulsed mid-LOAD after 2 bytes -> ignored; the next 2 bytes complete word 0 at addr 0.
5. Assert i_reset_n low between bytes 2 and 3, release, i_start, send 4 bytes -> only the new word is written at addr 0; no strobe during or right after reset.
6. From DONE, i_start and reload 1 word plus HALT_WORD -> addresses restart at 0; o_done deasserts on start and reasserts at the end.
